// File: rtl/hiscore_pkg.sv
// Shared definitions for the hiscore dump reader: FSM states, config record
// layout and the HPS transfer indices.
package hiscore_pkg;

  typedef enum logic [1:0] {IDLE, SEEK, READ, CAPTURE} state_t;

  // One decoded config record; byte 0 and the pad byte are not kept.
  typedef struct packed {
    logic [23:0] base;
    logic [7:0]  len;
    logic [7:0]  start_val;
    logic [7:0]  end_val;
  } cfg_entry_t;

  // Byte offsets inside an 8-byte config record (address occupies 0..3).
  localparam logic [2:0] CFG_ADDR  = 3'd0;
  localparam logic [2:0] CFG_LEN   = 3'd4;
  localparam logic [2:0] CFG_START = 3'd5;
  localparam logic [2:0] CFG_END   = 3'd6;

  localparam logic [7:0] CFG_INDEX  = 8'd3;
  localparam logic [7:0] DUMP_INDEX = 8'd4;

endpackage

// File: rtl/hiscore_cfg_table.sv
// Config table: one 48-bit record per entry, byte-wise write from the HPS
// download, combinational read by entry index. Not reset on purpose; the
// top-level config_valid flag decides whether the contents are trusted.
module hiscore_cfg_table
  import hiscore_pkg::*;
#(
  parameter int MAX_ENTRIES = 16,
  localparam int IW = $clog2(MAX_ENTRIES)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_entry,
  input  logic [2:0]    wr_byte,
  input  logic [7:0]    wr_data,
  input  logic [IW-1:0] rd_entry,
  output cfg_entry_t    rd_data
);

  cfg_entry_t mem [MAX_ENTRIES];

  // Scatter the incoming byte into its field; address byte 0 and pad are dropped.
  always_ff @(posedge clk)
    if (wr_en)
      case (wr_byte)
        CFG_ADDR + 3'd1: mem[wr_entry].base[23:16] <= wr_data;
        CFG_ADDR + 3'd2: mem[wr_entry].base[15:8]  <= wr_data;
        CFG_ADDR + 3'd3: mem[wr_entry].base[7:0]   <= wr_data;
        CFG_LEN:         mem[wr_entry].len         <= wr_data;
        CFG_START:       mem[wr_entry].start_val   <= wr_data;
        CFG_END:         mem[wr_entry].end_val     <= wr_data;
        default: ;
      endcase

  assign rd_data = mem[rd_entry];

endmodule

// File: rtl/hiscore_reader.sv
// Hiscore dump reader: maps HPS upload byte offsets onto game RAM through a
// table of (base, length) regions loaded by an index-3 download. The walk
// position is kept between requests so sequential uploads need no seeking.
module hiscore_reader
  import hiscore_pkg::*;
#(
  parameter int ADDRESSWIDTH = 10,
  parameter int MAX_ENTRIES  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ioctl_download,
  input  logic                    ioctl_upload,
  input  logic                    ioctl_wr,
  input  logic                    ioctl_rd,
  input  logic [7:0]              ioctl_index,
  input  logic [24:0]             ioctl_addr,
  input  logic [7:0]              ioctl_dout,
  output logic [7:0]              ioctl_din,
  output logic                    ioctl_wait,
  output logic [ADDRESSWIDTH-1:0] ram_address,
  output logic                    ram_read,
  input  logic [7:0]              ram_dout,
  output logic                    pause,
  output logic                    config_valid
);

  localparam int IW = $clog2(MAX_ENTRIES);
  localparam logic [IW:0] ONE = (IW+1)'(1);

  state_t      state;
  logic        dl_q, up_q;
  logic [IW:0] cfg_cnt;
  logic [IW:0] cur_e;
  logic [24:0] cur_s;
  cfg_entry_t  ent;

  logic          is_cfg, cfg_wr, cfg_start, cfg_end;
  logic [IW-1:0] wr_entry;
  logic [24:0]   off, s_end;
  logic          unused_cfg;

  assign is_cfg    = ioctl_index == CFG_INDEX;
  assign cfg_wr    = ioctl_download & ioctl_wr & is_cfg;
  assign cfg_start = ioctl_download & ~dl_q & is_cfg;
  assign cfg_end   = ~ioctl_download & dl_q & is_cfg;
  assign wr_entry  = ioctl_addr[IW+2:3];

  assign off   = ioctl_addr - cur_s;
  assign s_end = cur_s + {17'b0, ent.len};
  // start/end values are stored for completeness but not needed to read RAM
  assign unused_cfg = ^{ent.start_val, ent.end_val};

  hiscore_cfg_table #(.MAX_ENTRIES(MAX_ENTRIES)) u_cfg (
    .clk      (clk),
    .wr_en    (cfg_wr),
    .wr_entry (wr_entry),
    .wr_byte  (ioctl_addr[2:0]),
    .wr_data  (ioctl_dout),
    .rd_entry (cur_e[IW-1:0]),
    .rd_data  (ent)
  );

  // Download bookkeeping: entry count, config_valid and the pause request.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      dl_q         <= 1'b0;
      up_q         <= 1'b0;
      cfg_cnt      <= '0;
      config_valid <= 1'b0;
      pause        <= 1'b0;
    end else begin
      dl_q  <= ioctl_download;
      up_q  <= ioctl_upload;
      pause <= ioctl_upload & config_valid;
      if (cfg_start)                      config_valid <= 1'b0;
      else if (cfg_end && cfg_cnt != '0)  config_valid <= 1'b1;
      if (cfg_wr) begin
        if (cfg_start || {1'b0, wr_entry} >= cfg_cnt) cfg_cnt <= {1'b0, wr_entry} + ONE;
      end else if (cfg_start) begin
        cfg_cnt <= '0;
      end
    end

  // Upload FSM: seek one entry per cycle, then a single RAM read and capture.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= IDLE;
      ioctl_din   <= 8'h00;
      ioctl_wait  <= 1'b0;
      ram_read    <= 1'b0;
      ram_address <= '0;
      cur_e       <= '0;
      cur_s       <= '0;
    end else if (state != IDLE && !ioctl_upload) begin
      state      <= IDLE;
      ram_read   <= 1'b0;
      ioctl_wait <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ioctl_upload && !up_q) begin
            cur_e <= '0;
            cur_s <= '0;
          end
          if (ioctl_rd) begin
            if (ioctl_upload && ioctl_index == DUMP_INDEX && config_valid) begin
              ioctl_wait <= 1'b1;
              state      <= SEEK;
            end else begin
              ioctl_din <= 8'h00;
            end
          end
        end
        SEEK: begin
          if (ioctl_addr < cur_s) begin
            cur_e <= '0;
            cur_s <= '0;
          end else if (cur_e >= cfg_cnt) begin
            ioctl_din  <= 8'h00;
            ioctl_wait <= 1'b0;
            state      <= IDLE;
          end else if (ioctl_addr >= s_end) begin
            cur_e <= cur_e + ONE;
            cur_s <= s_end;
          end else begin
            ram_address <= ADDRESSWIDTH'(ent.base) + ADDRESSWIDTH'(off);
            ram_read    <= 1'b1;
            state       <= READ;
          end
        end
        READ: begin
          ram_read <= 1'b0;
          state    <= CAPTURE;
        end
        CAPTURE: begin
          ioctl_din  <= ram_dout;
          ioctl_wait <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end

endmodule

// File: tb/tb_hiscore_reader.sv
// Bench for hiscore_reader: directed scenarios plus randomized configs and
// offsets, checked against a region-walk reference model and a RAM array.
module tb_hiscore_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0, ioctl_upload = 1'b0, ioctl_wr = 1'b0, ioctl_rd = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic [9:0]  ram_address;
  logic        ram_read;
  logic [7:0]  ram_dout = 8'd0;
  logic        pause, config_valid;

  hiscore_reader #(.ADDRESSWIDTH(10), .MAX_ENTRIES(16)) dut (
    .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload),
    .ioctl_wr(ioctl_wr), .ioctl_rd(ioctl_rd), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .ram_address(ram_address), .ram_read(ram_read), .ram_dout(ram_dout),
    .pause(pause), .config_valid(config_valid)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:1023];
  logic [23:0] cfg_base [16];
  logic [7:0]  cfg_len  [16];
  int          cfg_n;
  int          checks = 0, errors = 0;
  int          pos_e;
  logic [24:0] pos_s;
  bit          mdl_valid;
  int          obs_wait;
  int          rd_total = 0;
  logic [9:0]  last_ra = '0;

  // game RAM: one-cycle read latency, junk on the bus when not reading
  always @(posedge clk) ram_dout <= ram_read ? mem[ram_address] : 8'($urandom);

  always @(negedge clk)
    if (ram_read === 1'b1) begin
      rd_total <= rd_total + 1;
      last_ra  <= ram_address;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Which region holds offset a, where that region starts, and the dump size.
  function automatic void model(input logic [24:0] a, output bit hit, output logic [9:0] ra,
                                output int tgt, output logic [24:0] st, output logic [24:0] tot);
    logic [24:0] s = '0;
    hit = 0; ra = '0; tgt = cfg_n; st = '0;
    for (int k = 0; k < cfg_n; k++) begin
      if (!hit && a >= s && a < s + 25'(cfg_len[k])) begin
        hit = 1; tgt = k; st = s;
        ra = 10'(25'(cfg_base[k]) + (a - s));
      end
      s = s + 25'(cfg_len[k]);
    end
    tot = s;
  endfunction

  task automatic load_cfg();
    logic [23:0] bs;
    logic [7:0]  d;
    @(negedge clk);
    ioctl_upload = 1'b0; ioctl_index = 8'd3; ioctl_download = 1'b1;
    for (int k = 0; k < cfg_n; k++)
      for (int b = 0; b < 8; b++) begin
        bs = cfg_base[k];
        case (b)
          1: d = bs[23:16];
          2: d = bs[15:8];
          3: d = bs[7:0];
          4: d = cfg_len[k];
          default: d = 8'($urandom);
        endcase
        @(negedge clk);
        ioctl_addr = 25'(k * 8 + b); ioctl_dout = d; ioctl_wr = 1'b1;
        @(negedge clk);
        ioctl_wr = 1'b0;
        if (k == 0 && b == 0) chk("cv_clear_on_dl", config_valid, 0);
      end
    @(negedge clk); ioctl_download = 1'b0;
    @(negedge clk); @(negedge clk);
    mdl_valid = 1;
    chk("config_valid", config_valid, 1);
  endtask

  task automatic up_restart();
    @(negedge clk); ioctl_upload = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("pause_off", pause, 0);
    ioctl_upload = 1'b1; ioctl_index = 8'd4;
    pos_e = 0; pos_s = '0;
    @(negedge clk);
    chk("pause_on", pause, {31'b0, mdl_valid});
  endtask

  task automatic rd_chk(input logic [24:0] a, input logic [7:0] idx);
    bit hit, rs;
    logic [9:0] ra;
    int tgt, r0, steps, ew;
    logic [24:0] st, tot;
    logic [7:0] ed;
    model(a, hit, ra, tgt, st, tot);
    @(negedge clk);
    r0 = rd_total;
    ioctl_addr = a; ioctl_index = idx; ioctl_rd = 1'b1;
    @(negedge clk);
    ioctl_rd = 1'b0;
    obs_wait = 0;
    while (ioctl_wait === 1'b1 && obs_wait < 100) begin
      obs_wait++;
      @(negedge clk);
    end
    if (mdl_valid && ioctl_upload && idx == 8'd4) begin
      rs    = a < pos_s;
      steps = (rs ? 1 : 0) + tgt - (rs ? 0 : pos_e);
      ew    = hit ? steps + 3 : steps + 1;
      if (hit) begin pos_e = tgt;   pos_s = st;  end
      else     begin pos_e = cfg_n; pos_s = tot; end
    end else begin
      ew = 0; hit = 0;
    end
    ed = hit ? mem[ra] : 8'h00;
    chk("wait_cycles", obs_wait, ew);
    chk("ioctl_din", ioctl_din, ed);
    chk("ram_reads", rd_total - r0, hit ? 1 : 0);
    if (hit) chk("ram_address", last_ra, ra);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mdl_valid = 0; pos_e = 0; pos_s = '0;
    repeat (3) @(negedge clk);
    chk("rst_din", ioctl_din, 0);
    chk("rst_wait", ioctl_wait, 0);
    chk("rst_ram_read", ram_read, 0);
    chk("rst_ram_address", ram_address, 0);
    chk("rst_pause", pause, 0);
    chk("rst_config_valid", config_valid, 0);
    reset = 1'b0;

    // no config yet: read returns zero without wait
    ioctl_upload = 1'b1;
    rd_chk(25'd0, 8'd4);

    // two regions: 0x100 x4, 0x200 x2
    cfg_n = 2;
    cfg_base[0] = 24'h000100; cfg_len[0] = 8'd4;
    cfg_base[1] = 24'h000200; cfg_len[1] = 8'd2;
    load_cfg();
    up_restart();
    for (int a = 0; a < 6; a++) rd_chk(25'(a), 8'd4);

    rd_chk(25'd1, 8'd4);
    rd_chk(25'd5, 8'd4);
    chk("seek_one_wait", obs_wait, 4);
    chk("seek_one_addr", last_ra, 10'h201);

    rd_chk(25'd3, 8'd4);
    rd_chk(25'd0, 8'd4);
    chk("restart_addr", last_ra, 10'h100);

    rd_chk(25'd6, 8'd4);
    chk("beyond_din", ioctl_din, 0);
    rd_chk(25'd2, 8'd4);
    rd_chk(25'd2, 8'd3);

    // upload dropped mid-request aborts on the next cycle
    @(negedge clk);
    ioctl_addr = 25'd5; ioctl_index = 8'd4; ioctl_rd = 1'b1;
    @(negedge clk); ioctl_rd = 1'b0; ioctl_upload = 1'b0;
    @(negedge clk);
    chk("abort_wait", ioctl_wait, 0);
    chk("abort_ram_read", ram_read, 0);
    up_restart();
    rd_chk(25'd4, 8'd4);

    // zero-length first region is skipped
    cfg_n = 2;
    cfg_base[0] = 24'h000333; cfg_len[0] = 8'd0;
    cfg_base[1] = 24'h000010; cfg_len[1] = 8'd1;
    load_cfg();
    up_restart();
    rd_chk(25'd0, 8'd4);
    chk("zero_len_addr", last_ra, 10'h010);

    // randomized configs and offsets
    for (int r = 0; r < 4; r++) begin
      int tot;
      cfg_n = $urandom_range(1, 6);
      tot = 0;
      for (int k = 0; k < cfg_n; k++) begin
        cfg_base[k] = 24'($urandom);
        cfg_len[k]  = 8'($urandom_range(0, 5));
        tot += int'(cfg_len[k]);
      end
      load_cfg();
      up_restart();
      for (int i = 0; i < 30; i++) begin
        if ($urandom_range(0, 9) == 0) up_restart();
        rd_chk(25'($urandom_range(0, tot + 2)), 8'd4);
      end
    end

    // reset while the RAM read is in flight
    cfg_n = 2;
    cfg_base[0] = 24'h000100; cfg_len[0] = 8'd4;
    cfg_base[1] = 24'h000200; cfg_len[1] = 8'd2;
    load_cfg();
    up_restart();
    @(negedge clk);
    ioctl_addr = 25'd4; ioctl_index = 8'd4; ioctl_rd = 1'b1;
    @(negedge clk); ioctl_rd = 1'b0;
    for (int i = 0; i < 20 && ram_read !== 1'b1; i++) @(negedge clk);
    chk("pre_rst_ram_read", ram_read, 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_ram_read", ram_read, 0);
    chk("rst_mid_wait", ioctl_wait, 0);
    chk("rst_mid_config_valid", config_valid, 0);
    chk("rst_mid_pause", pause, 0);
    @(negedge clk); reset = 1'b0;
    mdl_valid = 0;
    rd_chk(25'd0, 8'd4);
    chk("post_rst_pause", pause, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hiscore_reader.md
HISCORE_READER -- requirements
Module: hiscore_reader

Interface
REQ-001 Parameter ADDRESSWIDTH, default 10, is the width of the game RAM address bus.
REQ-002 Parameter MAX_ENTRIES, default 16, is the number of config table entries held (4-bit index).
REQ-003 clk  in  1  sole clock; all logic is on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 ioctl_download  in  1  HPS download in progress.
REQ-006 ioctl_upload  in  1  HPS upload (dump read-back) in progress.
REQ-007 ioctl_wr  in  1  download byte strobe.
REQ-008 ioctl_rd  in  1  upload byte request strobe, one cycle.
REQ-009 ioctl_index  in  8  transfer index; 3 = config, 4 = dump.
REQ-010 ioctl_addr  in  25  byte offset of the current transfer.
REQ-011 ioctl_dout  in  8  download data byte.
REQ-012 ioctl_din  out  8  upload data byte returned to HPS.
REQ-013 ioctl_wait  out  1  HPS must hold ioctl_addr and issue no new ioctl_rd while high.
REQ-014 ram_address  out  ADDRESSWIDTH  game RAM read address.
REQ-015 ram_read  out  1  game RAM read enable.
REQ-016 ram_dout  in  8  game RAM read data, valid one cycle after ram_read.
REQ-017 pause  out  1  game core halt request.
REQ-018 config_valid  out  1  config table loaded and at least one entry present.

Function
REQ-019 Config record = 8 bytes per entry at ioctl_addr[6:3]: bytes 0-3 address (big-endian; byte 0 ignored, bytes 1-3 form a 24-bit base), byte 4 length, byte 5 start value, byte 6 end value, byte 7 pad.
REQ-020 Config writes occur only when ioctl_download & ioctl_wr & ioctl_index==3; entry count = highest ioctl_addr[6:3] written + 1.
REQ-021 config_valid rises on the falling edge of ioctl_download with index 3 and clears when a new index-3 download starts.
REQ-022 An entry with length 0 contributes zero bytes and is skipped by the walk.
REQ-023 Dump offset mapping: entry k covers offsets [S_k, S_k+len_k), S_0 = 0, S_k+1 = S_k + len_k; byte = game RAM[base_k + (ioctl_addr - S_k)], truncated to ADDRESSWIDTH bits.
REQ-024 States: IDLE, SEEK, READ, CAPTURE.
REQ-025 IDLE: on ioctl_rd with ioctl_upload & index 4 & config_valid, raise ioctl_wait and go to SEEK.
REQ-026 SEEK: one entry step per cycle; if ioctl_addr < S_cur, restart at entry 0 with S=0; if ioctl_addr >= S_cur+len_cur, advance entry; else go to READ.
REQ-027 SEEK past the last entry: ioctl_din = 8'h00, drop ioctl_wait, return to IDLE without a RAM access.
REQ-028 READ: drive ram_address and ram_read=1 for exactly one cycle, then go to CAPTURE.
REQ-029 CAPTURE: register ram_dout into ioctl_din, ram_read=0, ioctl_wait=0, return to IDLE.
REQ-030 Sequential upload latency: ioctl_rd to ioctl_wait low = 3 cycles when no entry step is needed, plus one cycle per entry stepped.
REQ-031 Walk position (entry, S) persists between requests and resets to 0 when ioctl_upload rises.
REQ-032 ioctl_rd when config_valid=0 or index≠4: ioctl_din = 8'h00, ioctl_wait stays low.
REQ-033 ioctl_rd while ioctl_wait is high is ignored.
REQ-034 pause = ioctl_upload & config_valid, registered (1-cycle lag).
REQ-035 ioctl_upload falling mid-request aborts to IDLE next cycle with ram_read=0 and ioctl_wait=0.
REQ-036 Offset arithmetic is 25-bit unsigned; S accumulates 8-bit lengths zero-extended.

Reset
REQ-037 Reset sets state=IDLE, ioctl_din=0, ioctl_wait=0, ram_read=0, ram_address=0, pause=0, config_valid=0, entry count=0, and walk position=0.
REQ-038 Config table contents are not cleared by reset; config_valid=0 suppresses their use.
REQ-039 Reset mid-transfer takes effect immediately; HPS retries after reset release.

Structure
REQ-040 The shared hiscore package holds the state enum, config field byte offsets (ADDR=0..3, LEN=4, START=5, END=6), and the index constants CFG_INDEX=3 and DUMP_INDEX=4.
REQ-041 The config table is one sub-module, hiscore_cfg_table: 16x48 storage, write port from download, asynchronous read by entry index.

Verification
REQ-042 Config {base=0x000100,len=4},{base=0x000200,len=2}; upload reads of addr 0..5 -> ram_address 0x100..0x103, 0x200, 0x201; ioctl_din matches the RAM model.
REQ-043 Same config; read addr 5 directly after addr 1 -> one SEEK step; wait high for 4 cycles; ram_address = 0x201.
REQ-044 Read addr 3, then addr 0 -> walk restarts; ram_address = 0x100.
REQ-045 Read addr 6 (beyond the dump) -> ioctl_din = 0x00; ram_read never asserted.
REQ-046 Entries {len=0},{base=0x010,len=1}; read addr 0 -> ram_address = 0x010.
REQ-047 Assert reset during READ -> ram_read, ioctl_wait, config_valid and pause are 0 in the same cycle; a read after reset release returns 0x00.
